seq_multiplier: RTL and testbench

Multi-cycle 32x32 -> 64-bit shift-add multiplier for the MIPS EX stage, implementing MULT/MULTU into HI/LO.
- Drives a thirtytwobitadder instance every cycle and consumes its sum and carryout.
- Sits beside the ALU and is fed from the ID/EX operand registers.
- The pipeline stalls on busy and reads hi/lo when done pulses.

---
 rtl/mips_pkg.sv | 34 +++
 rtl/thirtytwobitadder.sv | 22 ++
 rtl/seq_multiplier.sv | 142 ++++++++++++++
 tb/tb_seq_multiplier.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared MIPS EX-stage definitions. Holds the multiplier state
//               encoding, the iteration count, the MULT/MULTU funct codes used
//               by the decoder, and the operand-magnitude helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    // Multiplier FSM state encoding
    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_CALC = 2'd1;
    localparam logic [1:0] c_FIX  = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    // One shift-add iteration per multiplier bit
    localparam int c_MUL_ITER = 32;

    // R-type funct codes that select the multiplier
    localparam logic [5:0] c_FUNCT_MULT  = 6'h18;
    localparam logic [5:0] c_FUNCT_MULTU = 6'h19;

    // Magnitude of a 32-bit operand. Only signed operands are negated;
    // |0x80000000| stays 0x80000000, which is correct read as unsigned.
    function automatic logic [31:0] f_mag(input logic [31:0] x, input logic is_signed);
        if (is_signed && x[31]) begin
            return ~x + 32'd1;
        end
        return x;
    endfunction

endpackage : mips_pkg
`default_nettype wire

// File: rtl/thirtytwobitadder.sv
`default_nettype none
// ============================================================================
// Module      : thirtytwobitadder
// Description : 32-bit adder with carry in and carry out.
// Ports       : a, b     - 32-bit addends
//               carryin  - carry into bit 0
//               sum      - 32-bit sum
//               carryout - carry out of bit 31
// Revision    : 1.0 - initial release
// ============================================================================
module thirtytwobitadder (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        carryin,
    output logic [31:0] sum,
    output logic        carryout
);

    assign {carryout, sum} = {1'b0, a} + {1'b0, b} + {32'b0, carryin};

endmodule : thirtytwobitadder
`default_nettype wire

// File: rtl/seq_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : seq_multiplier
// Description : Multi-cycle 32x32 -> 64 shift-add multiplier (MULT/MULTU)
//               writing HI/LO. Operands are reduced to magnitudes, multiplied
//               unsigned over 32 iterations, then negated if the signs differ.
// Ports       : clk       - rising-edge clock
//               rst_n     - asynchronous active-low reset
//               start     - request, sampled only in IDLE
//               signed_op - 1 = MULT, 0 = MULTU (sampled with start)
//               a, b      - multiplicand / multiplier (sampled with start)
//               busy      - high while an operation is in flight
//               done      - one-cycle pulse, hi/lo valid from this cycle
//               hi, lo    - product[63:32] / product[31:0]
// Revision    : 1.0 - initial release
// ============================================================================
module seq_multiplier
    import mips_pkg::*;
#(
    parameter int WIDTH = 32,  // only 32 supported: the adder is fixed-width
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [2*WIDTH-1:0] r_p;       // {partial product, remaining multiplier bits}
    logic [WIDTH-1:0]   r_m;       // multiplicand magnitude
    logic [CNT_W-1:0]   r_count;
    logic               r_neg;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               w_busy_nxt;
    logic               w_done_nxt;
    logic [WIDTH-1:0]   w_sum;
    logic               w_cout;
    logic               w_last_iter;

    assign w_last_iter = (r_count == CNT_W'(c_MUL_ITER - 1));

    thirtytwobitadder u_adder (
        .a        (r_p[2*WIDTH-1:WIDTH]),
        .b        (r_m),
        .carryin  (1'b0),
        .sum      (w_sum),
        .carryout (w_cout)
    );

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (start) w_state_nxt = c_CALC;
            c_CALC:  if (w_last_iter) w_state_nxt = c_FIX;
            c_FIX:   w_state_nxt = c_DONE;
            c_DONE:  w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // ---------------- output logic ----------------
    // busy and done are registered: busy follows the state being entered,
    // done fires on the edge that leaves DONE, together with the hi/lo write.
    always_comb begin
        w_busy_nxt = (w_state_nxt != c_IDLE);
        w_done_nxt = (r_state == c_DONE);
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p     <= '0;
            r_m     <= '0;
            r_count <= '0;
            r_neg   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_m     <= f_mag(a, signed_op);
                        r_p     <= {{WIDTH{1'b0}}, f_mag(b, signed_op)};
                        r_count <= '0;
                        r_neg   <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                    end
                end
                c_CALC: begin
                    // Add-then-shift: the adder carry becomes the new MSB.
                    if (r_p[0]) begin
                        r_p <= {w_cout, w_sum, r_p[WIDTH-1:1]};
                    end else begin
                        r_p <= {1'b0, r_p[2*WIDTH-1:1]};
                    end
                    r_count <= r_count + CNT_W'(1);
                end
                c_FIX: begin
                    if (r_neg) begin
                        r_p <= ~r_p + (2*WIDTH)'(1);
                    end
                end
                c_DONE: begin
                    r_hi <= r_p[2*WIDTH-1:WIDTH];
                    r_lo <= r_p[WIDTH-1:0];
                end
                default: ;
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule : seq_multiplier
`default_nettype wire

// File: tb/tb_seq_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_multiplier
// Description : Self-checking bench for seq_multiplier. Results are compared
//               against a plain-arithmetic 64-bit product of the sign- or
//               zero-extended operands.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_multiplier;

    localparam int c_LAT     = 34;
    localparam int c_TIMEOUT = 100;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        signed_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_vec = 0;
    int n_err = 0;

    seq_multiplier #(.WIDTH(32), .CNT_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .signed_op (signed_op),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: product of the operands extended to 64 bits.
    function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y,
                                            input logic s);
        logic [63:0] xe;
        logic [63:0] ye;
        xe = s ? {{32{x[31]}}, x} : {32'b0, x};
        ye = s ? {{32{y[31]}}, y} : {32'b0, y};
        return xe * ye;
    endfunction

    // Called #1 after a rising edge; start is seen by the next edge.
    task automatic start_op(input logic [31:0] x, input logic [31:0] y, input logic s);
        a = x; b = y; signed_op = s; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Counts edges until done is seen; bounded.
    task automatic wait_done(output int cyc, output bit timed_out);
        cyc = 0;
        timed_out = 1'b0;
        forever begin
            @(posedge clk); #1;
            cyc++;
            if (done) break;
            if (cyc >= c_TIMEOUT) begin
                timed_out = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; signed_op = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if ({busy, done, hi, lo} !== 66'b0) begin
            n_err++;
            $display("FAIL reset: busy=%b done=%b hi=%h lo=%h, want all zero", busy, done, hi, lo);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [31:0] ta [5] = '{32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        logic [31:0] tb [5] = '{32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF};
        logic        ts [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [63:0] want [5] = '{64'h0000_0000_0000_000F, 64'hFFFF_FFFE_0000_0001,
                                  64'h0000_0000_0000_0001, 64'hFFFF_FFFF_0000_0000,
                                  64'hFFFF_FFFF_8000_0001};
        int cyc;
        bit to;
        for (int i = 0; i < 5; i++) begin
            start_op(ta[i], tb[i], ts[i]);
            n_vec++;
            if (busy !== 1'b1) begin
                n_err++;
                $display("FAIL directed%0d busy: got %b want 1", i, busy);
            end
            wait_done(cyc, to);
            n_vec++;
            if (to || cyc != c_LAT) begin
                n_err++;
                $display("FAIL directed%0d latency: got %0d (timeout=%0b) want %0d", i, cyc, to, c_LAT);
            end
            n_vec++;
            if ({hi, lo} !== want[i]) begin
                n_err++;
                $display("FAIL directed%0d product: got %h_%h want %h", i, hi, lo, want[i]);
            end
            @(posedge clk); #1;
            n_vec++;
            if (done !== 1'b0) begin
                n_err++;
                $display("FAIL directed%0d done width: got %b want 0 after one cycle", i, done);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] corner [5] = '{32'h0, 32'h1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
        logic [31:0] x;
        logic [31:0] y;
        logic        s;
        logic [63:0] want;
        int cyc;
        bit to;
        for (int i = 0; i < 24; i++) begin
            x = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
            y = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
            s = 1'($urandom_range(0, 1));
            want = ref_mul(x, y, s);
            start_op(x, y, s);
            wait_done(cyc, to);
            n_vec++;
            if (to || cyc != c_LAT || {hi, lo} !== want) begin
                n_err++;
                $display("FAIL random%0d: a=%h b=%h s=%b got %h_%h lat %0d want %h lat %0d",
                         i, x, y, s, hi, lo, cyc, want, c_LAT);
            end
        end
    endtask

    // Start while busy is ignored; restart in the done cycle is accepted.
    task automatic test_back_to_back();
        int cyc;
        bit to;
        start_op(32'd2, 32'd2, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        start_op(32'd7, 32'd6, 1'b0);
        wait_done(cyc, to);
        n_vec++;
        if (to || cyc != c_LAT - 11 || {hi, lo} !== 64'd4) begin
            n_err++;
            $display("FAIL ignore_busy: got lo=%0d hi=%h lat %0d want lo=4 hi=0 lat %0d",
                     lo, hi, cyc, c_LAT - 11);
        end
        // Still in the done cycle: request the next operation.
        start_op(32'd7, 32'd6, 1'b0);
        wait_done(cyc, to);
        n_vec++;
        if (to || cyc != c_LAT || {hi, lo} !== 64'd42) begin
            n_err++;
            $display("FAIL restart_in_done: got lo=%0d lat %0d want lo=42 lat %0d", lo, cyc, c_LAT);
        end
        // No stray completion from the ignored request.
        wait_done(cyc, to);
        n_vec++;
        if (!to) begin
            n_err++;
            $display("FAIL extra_done: got done after %0d cycles want none", cyc);
        end
    endtask

    // start held high: a new operation each time IDLE is reached.
    task automatic test_start_held();
        int cyc;
        bit to;
        a = 32'd3; b = 32'd4; signed_op = 1'b0; start = 1'b1;
        wait_done(cyc, to);
        n_vec++;
        if (to || cyc != c_LAT + 1 || lo !== 32'd12) begin
            n_err++;
            $display("FAIL held_first: got lo=%0d lat %0d want lo=12 lat %0d", lo, cyc, c_LAT + 1);
        end
        a = 32'hFFFF_FFFD; b = 32'd5; signed_op = 1'b1;
        wait_done(cyc, to);
        start = 1'b0;
        n_vec++;
        if (to || cyc != c_LAT + 1 || {hi, lo} !== ref_mul(32'hFFFF_FFFD, 32'd5, 1'b1)) begin
            n_err++;
            $display("FAIL held_second: got %h_%h interval %0d want %h interval %0d",
                     hi, lo, cyc, ref_mul(32'hFFFF_FFFD, 32'd5, 1'b1), c_LAT + 1);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        int cyc;
        bit to;
        start_op(32'd5, 32'd9, 1'b0);
        repeat (14) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({busy, done, hi, lo} !== 66'b0) begin
            n_err++;
            $display("FAIL reset_mid: busy=%b done=%b hi=%h lo=%h want all zero", busy, done, hi, lo);
        end
        @(posedge clk); #2;
        rst_n = 1'b1;
        wait_done(cyc, to);
        n_vec++;
        if (!to || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_done: got done at %0d busy=%b want no done, busy 0", cyc, busy);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_start_held();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_seq_multiplier
`default_nettype wire
